uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 142 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo: byte FIFO in front of an 8N1 serialiser (LSB first).
// Bytes queue up while a frame is on the line. Back-to-back frames run with
// no idle gap between the stop bit and the next start bit.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        busy,
  output logic                        tx
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int BW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(BIT_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [7:0]      shift_reg, shift_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [BW-1:0]   baud_cnt, baud_cnt_next;
  logic            tx_next;
  logic            push, pop, baud_done;

  // The extra pointer bit lets the difference span 0..FIFO_DEPTH.
  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == DEPTH_FULL);
  assign busy      = (state != IDLE) || (count != '0);
  assign push      = wr_en && !full;
  assign baud_done = (baud_cnt == BAUD_LAST);

  // Byte storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // FIFO pointers; a push blocked by full is not rescued by a same-cycle pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Frame sequencing: pick next state, next line level and next shifter value.
  always_comb begin
    state_next    = state;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx;
    baud_cnt_next = baud_cnt + 1'b1;
    tx_next       = tx;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_next = '0;
        if (count != '0) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr[AW-1:0]];
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          tx_next       = shift_reg[0];
          state_next    = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          shift_next    = {1'b0, shift_reg[7:1]};
          if (bit_idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
            tx_next      = shift_reg[1];
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          if (count != '0) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr[AW-1:0]];
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset forces the line high at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      baud_cnt  <= '0;
      tx        <= 1'b1;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_idx   <= bit_idx_next;
      baud_cnt  <= baud_cnt_next;
      tx        <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// tb_uart_tx_fifo: frame-level reference model compared every cycle, a line
// decoder that recovers the transmitted bytes, and directed scenarios.
module tb_uart_tx_fifo;

  localparam int BIT   = 10;
  localparam int FRAME = 10 * BIT;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic [3:0] count;
  logic       busy;
  logic       tx;

  int checks = 0;
  int errors = 0;
  bit tb_done = 1'b0;

  // Reference model: queued bytes plus the position inside the current frame.
  logic [7:0] mq[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_byte = 8'h00;

  // Line decoder state and the bytes it has recovered.
  logic [7:0] rx_q[$];
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;

  uart_tx_fifo #(
    .CLK_FREQ  (1000),
    .BAUD_RATE (100),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .full   (full),
    .count  (count),
    .busy   (busy),
    .tx     (tx)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s timed out at %0t", name, $time);
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] data);
    @(negedge clk);
    wr_en   = en;
    wr_data = data;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitIdle(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!busy && !m_active && mq.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) reportTimeout("wait_idle");
  endtask

  function automatic logic model_tx();
    int slot;
    if (!m_active) return 1'b1;
    slot = m_pos / BIT;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_byte[slot-1];
  endfunction

  // Advance the reference model on each rising edge from the sampled inputs.
  always @(posedge clk) begin
    bit do_push;
    bit frame_end;
    bit do_pop;
    if (reset) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      do_push   = wr_en && (mq.size() < DEPTH);
      frame_end = m_active && (m_pos == FRAME - 1);
      do_pop    = (!m_active || frame_end) && (mq.size() > 0);
      if (do_pop) begin
        m_byte   = mq.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end else if (frame_end) begin
        m_active = 1'b0;
      end else if (m_active) begin
        m_pos++;
      end
      if (do_push) mq.push_back(wr_data);
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (!reset && !tb_done) begin
      checkOutput("tx", tx, model_tx());
      checkOutput("count", count, mq.size());
      checkOutput("full", full, mq.size() == DEPTH);
      checkOutput("busy", busy, m_active || mq.size() != 0);
    end
  end

  // Recover bytes from the line by sampling mid-bit after each falling start edge.
  always @(negedge clk) begin
    if (reset) begin
      rx_active = 1'b0;
      rx_cnt    = 0;
    end else if (!rx_active) begin
      if (tx == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 15 && rx_cnt <= 85 && (rx_cnt % 10) == 5) begin
        rx_byte[(rx_cnt - 15) / 10] = tx;
      end
      if (rx_cnt == 95) begin
        checkOutput("rx_stop_bit", tx, 1'b1);
        rx_q.push_back(rx_byte);
        rx_active = 1'b0;
      end
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios.
  initial begin
    bit found;
    int sent;
    int max_count;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tick(2);
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_full", full, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    reset = 1'b0;

    // Single byte 0x55 into an idle block.
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t1_count_after_push", count, 1);
    checkOutput("t1_tx_after_push", tx, 1'b1);
    tick(1);
    checkOutput("t1_start_low", tx, 1'b0);
    checkOutput("t1_count_popped", count, 0);
    tick(10);
    checkOutput("t1_bit0", tx, 1'b1);
    tick(10);
    checkOutput("t1_bit1", tx, 1'b0);
    tick(79);
    checkOutput("t1_busy_last", busy, 1'b1);
    checkOutput("t1_stop_high", tx, 1'b1);
    tick(1);
    checkOutput("t1_busy_clear", busy, 1'b0);
    tick(2);
    checkOutput("t1_rx_size", rx_q.size(), 1);
    if (rx_q.size() > 0) checkOutput("t1_rx_byte", rx_q[0], 8'h55);
    rx_q.delete();

    // Two back-to-back bytes: no idle gap between frames.
    applyStimulus(1'b1, 8'hA3);
    applyStimulus(1'b1, 8'h0F);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t2_start1", tx, 1'b0);
    tick(99);
    checkOutput("t2_stop1", tx, 1'b1);
    tick(1);
    checkOutput("t2_start2_no_gap", tx, 1'b0);
    waitIdle(400);
    checkOutput("t2_rx_size", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      checkOutput("t2_rx0", rx_q[0], 8'hA3);
      checkOutput("t2_rx1", rx_q[1], 8'h0F);
    end
    rx_q.delete();

    // Ten pushes into an idle block, then a blocked push on the pop edge.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'(i));
      if (i == 9) begin
        checkOutput("t3_full_after_9", full, 1'b1);
        checkOutput("t3_count_after_9", count, 8);
      end
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("t3_count_after_drop", count, 8);
    found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (m_active && m_pos == FRAME - 1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) reportTimeout("t5_frame_end");
    checkOutput("t5_full_before_pop", full, 1'b1);
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    applyStimulus(1'b0, 8'h00);
    checkOutput("t5_count_after_pop", count, 7);
    checkOutput("t5_full_after_pop", full, 1'b0);
    waitIdle(1200);
    checkOutput("t3_rx_size", rx_q.size(), 9);
    if (rx_q.size() == 9) begin
      for (int i = 0; i < 9; i++) checkOutput("t3_rx_byte", rx_q[i], 8'(i));
    end
    rx_q.delete();

    // Reset in the middle of a 0xFF frame with three bytes queued.
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33);
    applyStimulus(1'b0, 8'h00);
    tick(30);
    checkOutput("t4_count_before", count, 3);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("t4_async_tx", tx, 1'b1);
    checkOutput("t4_async_count", count, 0);
    checkOutput("t4_async_busy", busy, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    tick(150);
    checkOutput("t4_no_frames", rx_q.size(), 0);
    applyStimulus(1'b1, 8'h41);
    applyStimulus(1'b0, 8'h00);
    waitIdle(300);
    checkOutput("t4_rx_size", rx_q.size(), 1);
    if (rx_q.size() == 1) checkOutput("t4_rx_byte", rx_q[0], 8'h41);
    rx_q.delete();

    // Twenty bytes paced by polling full; pointers wrap more than once.
    sent      = 0;
    max_count = 0;
    for (int n = 0; n < 5000 && sent < 20; n++) begin
      @(negedge clk);
      if (int'(count) > max_count) max_count = int'(count);
      if (!full) begin
        wr_en   = 1'b1;
        wr_data = 8'h60 + 8'(sent);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("t6_sent", sent, 20);
    waitIdle(2500);
    checkOutput("t6_max_count", max_count, 8);
    checkOutput("t6_rx_size", rx_q.size(), 20);
    if (rx_q.size() == 20) begin
      for (int i = 0; i < 20; i++) checkOutput("t6_rx_byte", rx_q[i], 8'h60 + 8'(i));
    end

    tb_done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
